bsg_manycore_pkt_send_queue: RTL and testbench
==============================================

// Module: bsg_manycore_pkt_send_queue
// PURPOSE
//  Output stage directly downstream of the manycore packet encoder. Buffers encoded
//  76-bit request packets in a small FIFO and injects them onto the mesh link under
//  credit-based flow control, one packet per cycle max. Upstream sees valid/ready;
//  the link side sees valid plus returned credits, with no ready signal.
// PARAMETERS
//  x_cord_width_p   4   x coordinate width
//  y_cord_width_p   5   y coordinate width
//  data_width_p     32  payload width; mask width = data_width_p/8
//  addr_width_p     20  word-address field width (packet carries addr_width_p-1 bits)
//  els_p            2   FIFO depth, >=2
//  credits_p        4   link credits at reset, >=1
//  packet_width_lp  76  derived = (addr_width_p-1)+2+data_width_p/8+data_width_p+2*(x+y)+1
// PORTS
//  clk_i          in   1                 clock, rising edge
//  reset_i        in   1                 asynchronous, active-high reset
//  v_i            in   1                 encoded packet valid
//  data_i         in   packet_width_lp   encoded packet (encoder data_o)
//  ready_o        out  1                 FIFO can accept; transfer = v_i & ready_o
//  link_v_o       out  1                 packet sent on link this cycle
//  link_data_o    out  packet_width_lp   packet on link
//  link_credit_i  in   1                 one credit returned by link this cycle
//  credits_o      out  clog2(credits_p+1) current credit count
//  empty_o        out  1                 FIFO empty and credits_o==credits_p (fence)
//  err_o          out  1                 sticky: credit returned while count full
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, credits=credits_p, err_o=0.
//    Outputs during reset: ready_o=1, link_v_o=0, empty_o=1, link_data_o=0.
//  - Reset mid-operation discards all buffered packets and restores all credits;
//    any upstream packet offered that cycle is not accepted and must be re-offered.
//  - Enqueue: v_i & ready_o writes data_i at tail. ready_o = ~full; it depends only
//    on registered state, never on v_i. v_i while ready_o=0 is ignored.
//  - Send: link_v_o = ~fifo_empty & (credits>0); link_data_o = head entry. Each cycle
//    with link_v_o=1 pops the head and decrements credits.
//  - Credits: send only -> -1; link_credit_i only -> +1; both -> unchanged.
//    link_credit_i at credits==credits_p with no send -> count held, err_o set
//    (sticky until reset). Count never wraps below 0 or above credits_p.
//  - Full FIFO + simultaneous send: ready_o stays 0 that cycle (registered full);
//    deassert next cycle. Empty FIFO + simultaneous enqueue: see bypass below.
//  - Minimum latency v_i -> link_v_o: 1 cycle (entry registered first).
//  - Order preserved: packets leave in acceptance order; payload bits unmodified.
//  - FIFO head/tail pointers wrap modulo els_p; occupancy counter 0..els_p.
// CONFIGURATION
//  BSG_MANYCORE_PKT_SEND_BYPASS_EN defined: when FIFO empty, credits>0 and v_i=1,
//    data_i is forwarded combinationally to link_data_o with link_v_o=1 the same
//    cycle (0-cycle latency); packet not written to FIFO; credit still consumed.
//    ready_o unchanged (still ~full).
//  Undefined: no combinational path from data_i/v_i to link outputs; latency >= 1.
// TESTING
//  1 Reset, v_i=1 one cycle with data_i=76'h0_1234_5678_9ABC_DEF0_123 -> link_v_o=1
//    next cycle (same cycle if BYPASS_EN), link_data_o equal, credits_o 4->3.
//  2 No credit returns, push 7 packets back-to-back -> exactly 4 sent, FIFO holds 2,
//    ready_o=0, 1 never accepted; pulse link_credit_i once -> 5th sent next cycle.
//  3 Steady state link_credit_i=1 every cycle, v_i=1 every cycle -> one packet/cycle,
//    credits_o constant, order matches input sequence 0..31.
//  4 credits=3, assert link_credit_i in a send cycle -> credits_o stays 3;
//    at credits=4, idle, link_credit_i=1 -> credits_o=4, err_o=1 and stays 1.
//  5 FIFO full, assert reset_i asynchronously mid-cycle -> ready_o=1, link_v_o=0,
//    credits_o=4, empty_o=1 immediately; buffered packets never appear on link.
//  6 Send 3 packets, return 3 credits over 5 cycles -> empty_o=0 until last credit,
//    then empty_o=1 the following cycle.

Source files
------------

// File: rtl/bsg_manycore_pkt_send_queue.sv
// Packet send queue: small FIFO feeding the mesh link under credit-based flow control.
// Optional same-cycle bypass of an empty queue: define BSG_MANYCORE_PKT_SEND_BYPASS_EN.
module bsg_manycore_pkt_send_queue #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 5,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 20,
  parameter int els_p          = 2,
  parameter int credits_p      = 4,
  localparam int packet_width_lp = (addr_width_p-1) + 2 + (data_width_p/8) + data_width_p
                                   + 2*(x_cord_width_p+y_cord_width_p) + 1,
  localparam int credit_width_lp = $clog2(credits_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  // Upstream valid/ready: a packet moves exactly on a cycle where v_i & ready_o;
  // ready_o is a function of registered state only, never of v_i.
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                       ready_o,
  output logic                       link_v_o,
  output logic [packet_width_lp-1:0] link_data_o,
  input  logic                       link_credit_i,
  output logic [credit_width_lp-1:0] credits_o,
  output logic                       empty_o,
  output logic                       err_o
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p+1);

  logic [packet_width_lp-1:0] mem_q [els_p];
  logic [ptr_width_lp-1:0]    head_q, head_d, tail_q, tail_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic                       err_q, err_d;

  logic fifo_empty, fifo_full, have_credit, bypass, deq, enq, send;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p-1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty  = (cnt_q == '0);
  assign fifo_full   = (cnt_q == cnt_width_lp'(els_p));
  assign have_credit = (credits_q != '0);

`ifdef BSG_MANYCORE_PKT_SEND_BYPASS_EN
  // Reset gating keeps the link quiet while reset is held.
  assign bypass = fifo_empty & have_credit & v_i & ~reset_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq  = ~fifo_empty & have_credit;
  assign send = deq | bypass;
  assign enq  = v_i & ~fifo_full & ~bypass;

  assign ready_o     = ~fifo_full;
  assign link_v_o    = send;
  assign link_data_o = bypass ? data_i : (fifo_empty ? '0 : mem_q[head_q]);
  assign credits_o   = credits_q;
  assign empty_o     = fifo_empty & (credits_q == credit_width_lp'(credits_p));
  assign err_o       = err_q;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    credits_d = credits_q;
    err_d     = err_q;
    if (deq) head_d = next_ptr(head_q);
    if (enq) tail_d = next_ptr(tail_q);
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A credit returned into a full count is a protocol error, never a wrap.
    if (send && !link_credit_i) begin
      credits_d = credits_q - 1'b1;
    end else if (link_credit_i && !send) begin
      if (credits_q == credit_width_lp'(credits_p)) err_d = 1'b1;
      else credits_d = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      credits_q <= credit_width_lp'(credits_p);
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= data_i;
  end

endmodule

// File: tb/tb_bsg_manycore_pkt_send_queue.sv
// Directed self-checking bench for bsg_manycore_pkt_send_queue (default build, no bypass).
module tb_bsg_manycore_pkt_send_queue;

  localparam int W = 76;

  logic         clk_i, reset_i, v_i, link_credit_i;
  logic [W-1:0] data_i, link_data_o;
  logic         ready_o, link_v_o, empty_o, err_o;
  logic [2:0]   credits_o;

  int total = 0;
  int bad   = 0;
  int sent_cnt = 0;
  logic [W-1:0] exp_q[$];

  bsg_manycore_pkt_send_queue dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .link_v_o(link_v_o), .link_data_o(link_data_o), .link_credit_i(link_credit_i),
    .credits_o(credits_o), .empty_o(empty_o), .err_o(err_o)
  );

  // clock/reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pkt(input int i);
    return {12'hA5C ^ 12'(i), 32'hDEAD_0000 + 32'(i), 32'h1357_0000 ^ 32'(i*7)};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    v_i = 1'b0; link_credit_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // scoreboard: every link beat must match the oldest accepted packet
  always @(negedge clk_i) begin
    if (link_v_o) begin
      sent_cnt++;
      check("mon_expected_send", 76'(exp_q.size() != 0), 76'd1);
      if (exp_q.size() != 0) check("mon_link_data", link_data_o, exp_q.pop_front());
    end
  end

  initial begin
    logic [W-1:0] d1;
    int acc;
    logic [4:0] pat;
    reset_i = 1'b1; v_i = 1'b0; data_i = '0; link_credit_i = 1'b0;

    // reset state
    mid();
    check("rst_ready", 76'(ready_o), 76'd1);
    check("rst_link_v", 76'(link_v_o), 76'd0);
    check("rst_link_data", link_data_o, 76'd0);
    check("rst_empty", 76'(empty_o), 76'd1);
    check("rst_credits", 76'(credits_o), 76'd4);
    check("rst_err", 76'(err_o), 76'd0);
    step();
    reset_i = 1'b0;
    step();

    // 1: single packet, one cycle latency
    d1 = 76'h1234_5678_9ABC_DEF0_123;
    v_i = 1'b1; data_i = d1; exp_q.push_back(d1);
    mid();
    check("t1_no_same_cycle", 76'(link_v_o), 76'd0);
    step();
    v_i = 1'b0;
    mid();
    check("t1_link_v", 76'(link_v_o), 76'd1);
    check("t1_credits_before", 76'(credits_o), 76'd4);
    step();
    check("t1_credits_after", 76'(credits_o), 76'd3);
    check("t1_link_v_after", 76'(link_v_o), 76'd0);
    link_credit_i = 1'b1; step(); link_credit_i = 1'b0;
    check("t1_credits_back", 76'(credits_o), 76'd4);

    // 2: no credit returns, 7 back-to-back offers
    sent_cnt = 0; acc = 0;
    for (int i = 0; i < 7; i++) begin
      v_i = 1'b1; data_i = pkt(i);
      if (ready_o) begin exp_q.push_back(pkt(i)); acc++; end
      step();
    end
    v_i = 1'b0;
    mid();
    check("t2_accepted", 76'(acc), 76'd6);
    check("t2_sent", 76'(sent_cnt), 76'd4);
    check("t2_ready_full", 76'(ready_o), 76'd0);
    check("t2_credits_zero", 76'(credits_o), 76'd0);
    check("t2_stalled", 76'(link_v_o), 76'd0);
    step();
    link_credit_i = 1'b1; step(); link_credit_i = 1'b0;
    mid();
    check("t2_fifth_sent", 76'(link_v_o), 76'd1);
    step();
    check("t2_ready_again", 76'(ready_o), 76'd1);
    link_credit_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    link_credit_i = 1'b0;
    mid();
    check("t2_sent_total", 76'(sent_cnt), 76'd6);
    check("t2_credits_full", 76'(credits_o), 76'd4);
    check("t2_empty", 76'(empty_o), 76'd1);
    check("t2_err_clear", 76'(err_o), 76'd0);
    step();

    // 3: steady state, one packet per cycle with one credit back per cycle
    sent_cnt = 0;
    for (int c = 0; c <= 32; c++) begin
      v_i = (c < 32); data_i = pkt(100 + c); link_credit_i = (c >= 1);
      if (c < 32) begin
        check("t3_ready", 76'(ready_o), 76'd1);
        exp_q.push_back(pkt(100 + c));
      end
      mid();
      if (c >= 1) begin
        check("t3_link_v", 76'(link_v_o), 76'd1);
        check("t3_credits_const", 76'(credits_o), 76'd4);
      end
      step();
    end
    idle(1);
    check("t3_sent", 76'(sent_cnt), 76'd32);
    check("t3_drained", 76'(exp_q.size()), 76'd0);
    check("t3_err", 76'(err_o), 76'd0);

    // 4: credit in a send cycle holds count; credit at full count flags err
    v_i = 1'b1; data_i = pkt(200); exp_q.push_back(pkt(200)); step();
    v_i = 1'b1; data_i = pkt(201); exp_q.push_back(pkt(201)); step();
    v_i = 1'b0;
    check("t4_credits3", 76'(credits_o), 76'd3);
    link_credit_i = 1'b1;
    mid();
    check("t4_send_cycle", 76'(link_v_o), 76'd1);
    step();
    check("t4_credits_held", 76'(credits_o), 76'd3);
    step();
    check("t4_credits4", 76'(credits_o), 76'd4);
    check("t4_err_before", 76'(err_o), 76'd0);
    step();
    link_credit_i = 1'b0;
    check("t4_credits_cap", 76'(credits_o), 76'd4);
    check("t4_err_set", 76'(err_o), 76'd1);
    idle(3);
    check("t4_err_sticky", 76'(err_o), 76'd1);

    // 5: async reset with a full FIFO
    for (int i = 0; i < 6; i++) begin
      v_i = 1'b1; data_i = pkt(300 + i); exp_q.push_back(pkt(300 + i)); step();
    end
    v_i = 1'b1; data_i = pkt(399);
    check("t5_full", 76'(ready_o), 76'd0);
    #2 reset_i = 1'b1;
    #1;
    exp_q.delete();
    check("t5_rst_ready", 76'(ready_o), 76'd1);
    check("t5_rst_link_v", 76'(link_v_o), 76'd0);
    check("t5_rst_credits", 76'(credits_o), 76'd4);
    check("t5_rst_empty", 76'(empty_o), 76'd1);
    check("t5_rst_err", 76'(err_o), 76'd0);
    step();
    reset_i = 1'b0; v_i = 1'b0;
    sent_cnt = 0;
    idle(4);
    check("t5_no_stale_send", 76'(sent_cnt), 76'd0);
    check("t5_empty_after", 76'(empty_o), 76'd1);

    // 6: fence: empty_o waits for the last credit
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; data_i = pkt(400 + i); exp_q.push_back(pkt(400 + i)); step();
    end
    v_i = 1'b0;
    step();
    check("t6_credits1", 76'(credits_o), 76'd1);
    pat = 5'b10101;
    for (int j = 0; j < 5; j++) begin
      link_credit_i = pat[j];
      mid();
      check("t6_not_empty", 76'(empty_o), 76'd0);
      step();
    end
    link_credit_i = 1'b0;
    check("t6_empty", 76'(empty_o), 76'd1);
    check("t6_credits4", 76'(credits_o), 76'd4);
    check("t6_all_sent", 76'(exp_q.size()), 76'd0);
    idle(2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
